// File: rtl/vector_check_seq.sv
// Clocked vector sequencer: applies stored {inputs, expected} vectors to a logic-cell DUT,
// samples its response after a settle window and accumulates a pass/fail verdict.
module vector_check_seq #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int VW = IN_W + OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VW-1:0]    wr_data,
  output logic             wr_err,
  input  logic             start,
  output logic [IN_W-1:0]  dut_in,
  output logic             vec_valid,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_count,
  output logic [AW-1:0]    first_err_addr
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SLAST   = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [AW-1:0] ILAST   = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_V = (AW + 1)'(DEPTH);

  logic [VW-1:0] tbl [2**AW];
  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic [SW-1:0] scnt;
  logic          idle_like;
  logic          addr_ok;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign addr_ok   = ({1'b0, wr_addr} < DEPTH_V);
  assign busy      = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign pass      = done && (err_count == '0);

  // Table storage is deliberately left out of reset so vectors survive an aborted run.
  always_ff @(posedge clk) begin
    if (!rst && wr_en && idle_like && addr_ok)
      tbl[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      dut_in         <= '0;
      vec_valid      <= 1'b0;
      wr_err         <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      idx            <= '0;
      scnt           <= '0;
    end else begin
      wr_err <= wr_en && !(idle_like && addr_ok);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_APPLY;
            idx            <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
          end
        end
        S_APPLY: begin
          dut_in    <= tbl[idx][VW-1:OUT_W];
          vec_valid <= 1'b1;
          scnt      <= '0;
          state     <= (SETTLE > 0) ? S_SETTLE : S_CHECK;
        end
        S_SETTLE: begin
          if (scnt == SLAST) state <= S_CHECK;
          else               scnt  <= scnt + SW'(1);
        end
        S_CHECK: begin
          if (dut_out != tbl[idx][OUT_W-1:0]) begin
            err_count <= err_count + CW'(1);
            if (err_count == '0) first_err_addr <= idx;
          end
          if (idx == ILAST) begin
            state     <= S_DONE;
            vec_valid <= 1'b0;
          end else begin
            idx   <= idx + AW'(1);
            state <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_check_seq.sv
// Scoreboard bench for vector_check_seq: two instances (DEPTH=4/SETTLE=1 and DEPTH=1/SETTLE=0)
// each driving a combinational implication cell (~a | b).
module tb_vector_check_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: DEPTH=4, SETTLE=1
  logic       rst4, wr_en4, wr_err4, start4, vec_valid4, busy4, done4, pass4;
  logic [1:0] wr_addr4, dut_in4, first4;
  logic [2:0] wr_data4, err4;
  logic [0:0] dut_out4;
  assign dut_out4 = ~dut_in4[1] | dut_in4[0];

  vector_check_seq #(.IN_W(2), .OUT_W(1), .DEPTH(4), .SETTLE(1)) dut4 (
    .clk(clk), .rst(rst4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .wr_err(wr_err4), .start(start4), .dut_in(dut_in4), .vec_valid(vec_valid4),
    .dut_out(dut_out4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .first_err_addr(first4)
  );

  // Instance B: DEPTH=1, SETTLE=0
  logic       rst1, wr_en1, wr_err1, start1, vec_valid1, busy1, done1, pass1;
  logic [0:0] wr_addr1, first1, err1;
  logic [1:0] dut_in1;
  logic [2:0] wr_data1;
  logic [0:0] dut_out1;
  assign dut_out1 = ~dut_in1[1] | dut_in1[0];

  vector_check_seq #(.IN_W(2), .OUT_W(1), .DEPTH(1), .SETTLE(0)) dut1 (
    .clk(clk), .rst(rst1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .wr_err(wr_err1), .start(start1), .dut_in(dut_in1), .vec_valid(vec_valid1),
    .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_addr(first1)
  );

  typedef struct {
    int t0;
    int lat;
    int errs;
    int first;
    int pass;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: on every rising edge of done, pop and compare the expected verdict.
  logic pd4 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done4 && !pd4) begin
      if (q4.size() == 0) check("a_unexpected_done", 1, 0);
      else begin
        e = q4.pop_front();
        check("a_latency", cyc - e.t0, e.lat);
        check("a_err_count", int'(err4), e.errs);
        if (e.errs != 0) check("a_first_err_addr", int'(first4), e.first);
        check("a_pass", int'(pass4), e.pass);
      end
    end
    pd4 = done4;
  end

  logic pd1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done1 && !pd1) begin
      if (q1.size() == 0) check("b_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        check("b_latency", cyc - e.t0, e.lat);
        check("b_err_count", int'(err1), e.errs);
        check("b_pass", int'(pass1), e.pass);
      end
    end
    pd1 = done1;
  end

  task automatic write4(input logic [1:0] a, input logic [2:0] d);
    wr_en4 = 1'b1; wr_addr4 = a; wr_data4 = d;
    tick();
    wr_en4 = 1'b0;
  endtask

  task automatic run4(input bit push, input int errs, input int first, input int ps);
    exp_t e;
    start4 = 1'b1;
    e.t0 = cyc; e.lat = 13; e.errs = errs; e.first = first; e.pass = ps;
    if (push) q4.push_back(e);
    tick();
    start4 = 1'b0;
  endtask

  task automatic wait4();
    for (int i = 0; i < 200 && q4.size() != 0; i++) tick();
    check("a_run_timeout", q4.size(), 0);
  endtask

  initial begin
    exp_t e;
    rst4 = 1'b1; wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0; start4 = 1'b0;
    rst1 = 1'b1; wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; start1 = 1'b0;
    tick(); tick();
    check("rst_busy", int'(busy4), 0);
    check("rst_done", int'(done4), 0);
    check("rst_pass", int'(pass4), 0);
    check("rst_vec_valid", int'(vec_valid4), 0);
    check("rst_dut_in", int'(dut_in4), 0);
    check("rst_err_count", int'(err4), 0);
    check("rst_wr_err", int'(wr_err4), 0);
    rst4 = 1'b0; rst1 = 1'b0;

    // Table for ~a|b: 00->1, 01->1, 10->0, 11->1
    write4(2'd0, 3'b001);
    check("wr_ok_no_err", int'(wr_err4), 0);
    write4(2'd1, 3'b011);
    write4(2'd2, 3'b100);
    write4(2'd3, 3'b111);

    // 1: clean pass
    run4(1'b1, 0, 0, 1);
    wait4();
    check("done_dut_in_holds_last", int'(dut_in4), 3);
    check("done_vec_valid_low", int'(vec_valid4), 0);

    // 2: addr2 expected=1, written in the same cycle as start
    wr_en4 = 1'b1; wr_addr4 = 2'd2; wr_data4 = 3'b101;
    run4(1'b1, 1, 2, 0);
    wr_en4 = 1'b0;
    check("start_with_write_no_err", int'(wr_err4), 0);
    wait4();

    // 3: expected inverted at addr1 and addr3
    write4(2'd2, 3'b100);
    write4(2'd1, 3'b010);
    write4(2'd3, 3'b110);
    run4(1'b1, 2, 1, 0);
    wait4();
    write4(2'd1, 3'b011);
    write4(2'd3, 3'b111);

    // 4: reset during SETTLE of vector 1
    run4(1'b0, 0, 0, 0);
    repeat (4) tick();
    check("mid_run_busy", int'(busy4), 1);
    check("mid_run_dut_in_v1", int'(dut_in4), 1);
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    check("abort_busy", int'(busy4), 0);
    check("abort_done", int'(done4), 0);
    check("abort_vec_valid", int'(vec_valid4), 0);
    check("abort_dut_in", int'(dut_in4), 0);
    check("abort_err_count", int'(err4), 0);
    check("abort_first_err", int'(first4), 0);
    run4(1'b1, 0, 0, 1);
    wait4();

    // 5: start and write while busy are ignored
    run4(1'b1, 0, 0, 1);
    tick();
    start4 = 1'b1; wr_en4 = 1'b1; wr_addr4 = 2'd2; wr_data4 = 3'b101;
    tick();
    start4 = 1'b0; wr_en4 = 1'b0;
    check("busy_write_wr_err", int'(wr_err4), 1);
    tick();
    check("busy_write_wr_err_once", int'(wr_err4), 0);
    wait4();
    run4(1'b1, 0, 0, 1);
    wait4();

    // 6: DEPTH=1, SETTLE=0 instance
    wr_en1 = 1'b1; wr_addr1 = 1'b0; wr_data1 = 3'b111;
    tick();
    wr_en1 = 1'b0;
    check("b_wr_ok_no_err", int'(wr_err1), 0);
    start1 = 1'b1;
    e.t0 = cyc; e.lat = 3; e.errs = 0; e.first = 0; e.pass = 1;
    q1.push_back(e);
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 50 && q1.size() != 0; i++) tick();
    check("b_run_timeout", q1.size(), 0);
    wr_en1 = 1'b1; wr_addr1 = 1'b1; wr_data1 = 3'b000;
    tick();
    wr_en1 = 1'b0;
    check("b_bad_addr_wr_err", int'(wr_err1), 1);
    tick();
    check("b_bad_addr_wr_err_once", int'(wr_err1), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
